// File: rtl/cache_pkg.sv
// Shared configuration for the cache data array: default geometry, control
// state encoding and the per-byte parity helper.
package cache_pkg;

  localparam int DEF_WAYS           = 4;
  localparam int DEF_SETS           = 8;
  localparam int DEF_WORDS_PER_LINE = 4;
  localparam int DEF_WORD_WIDTH     = 32;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_FILL = 2'd2
  } state_e;

  // Even parity: the stored bit makes the total number of ones even.
  function automatic logic byte_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/cache_data_bank.sv
// One way of the cache data store: SETS x WORDS_PER_LINE words split into
// byte lanes, with a per-lane write enable, a whole-set clear and a registered read.
module cache_data_bank #(
  parameter int SETS           = 8,
  parameter int WORDS_PER_LINE = 4,
  parameter int LANES          = 4,
  parameter int LANE_W         = 8,
  localparam int SET_W      = $clog2(SETS),
  localparam int WORD_IDX_W = $clog2(WORDS_PER_LINE),
  localparam int DATA_W     = LANES * LANE_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  input  logic [SET_W-1:0]      clr_set,
  input  logic                  we,
  input  logic [SET_W-1:0]      wr_set,
  input  logic [WORD_IDX_W-1:0] wr_word,
  input  logic [LANES-1:0]      wr_be,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  re,
  input  logic [SET_W-1:0]      rd_set,
  input  logic [WORD_IDX_W-1:0] rd_word,
  output logic [DATA_W-1:0]     rd_data
);

  localparam int DEPTH = SETS * WORDS_PER_LINE;

  logic [DATA_W-1:0]           mem_q [DEPTH];
  logic [DATA_W-1:0]           mem_d [DEPTH];
  logic [DATA_W-1:0]           rd_data_q;
  logic [DATA_W-1:0]           rd_data_d;
  logic [SET_W+WORD_IDX_W-1:0] wr_addr;
  logic [SET_W+WORD_IDX_W-1:0] rd_addr;

  assign wr_addr = {wr_set, wr_word};
  assign rd_addr = {rd_set, rd_word};

  // Storage next state: a whole-set clear takes precedence over a lane write.
  always_comb begin
    mem_d = mem_q;
    if (clr) begin
      for (int i = 0; i < WORDS_PER_LINE; i++) begin
        mem_d[{clr_set, WORD_IDX_W'(i)}] = '0;
      end
    end else if (we) begin
      for (int l = 0; l < LANES; l++) begin
        if (wr_be[l]) begin
          mem_d[wr_addr][l*LANE_W +: LANE_W] = wr_data[l*LANE_W +: LANE_W];
        end else begin
          mem_d[wr_addr][l*LANE_W +: LANE_W] = mem_q[wr_addr][l*LANE_W +: LANE_W];
        end
      end
    end else begin
      mem_d = mem_q;
    end
  end

  // Read register loads only on a read, so the output holds between reads.
  always_comb begin
    rd_data_d = re ? mem_q[rd_addr] : rd_data_q;
  end

  // Array contents; cleared by the owner's init sweep, not by reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Read data register.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/cache_data_array.sv
// WAYS-way cache data store with post-reset clear sweep, CPU word access and a
// burst line-fill port. Define CACHE_DATA_PARITY_EN to store per-byte parity.
module cache_data_array
  import cache_pkg::*;
#(
  parameter int WAYS           = DEF_WAYS,
  parameter int SETS           = DEF_SETS,
  parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE,
  parameter int WORD_WIDTH     = DEF_WORD_WIDTH,
  localparam int WAY_W      = $clog2(WAYS),
  localparam int SET_W      = $clog2(SETS),
  localparam int WORD_IDX_W = $clog2(WORDS_PER_LINE),
  localparam int BE_W       = WORD_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  init_busy,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [SET_W-1:0]      req_set,
  input  logic [WAY_W-1:0]      req_way,
  input  logic [WORD_IDX_W-1:0] req_word,
  input  logic [BE_W-1:0]       req_be,
  input  logic [WORD_WIDTH-1:0] req_wdata,
  output logic                  rd_valid,
  output logic [WORD_WIDTH-1:0] rd_data,
  input  logic                  fill_start,
  input  logic [SET_W-1:0]      fill_set,
  input  logic [WAY_W-1:0]      fill_way,
  input  logic                  fill_valid,
  input  logic [WORD_WIDTH-1:0] fill_data,
  output logic                  fill_ready,
  output logic                  fill_done,
  output logic                  rd_perr,
  input  logic                  perr_inject
);

`ifdef CACHE_DATA_PARITY_EN
  localparam int LANE_W = 9;
`else
  localparam int LANE_W = 8;
`endif
  localparam int DATA_W = BE_W * LANE_W;
  localparam logic [SET_W-1:0]      LAST_SET  = SET_W'(SETS - 1);
  localparam logic [WORD_IDX_W-1:0] LAST_WORD = WORD_IDX_W'(WORDS_PER_LINE - 1);

  state_e                  state_q, state_d;
  logic [SET_W-1:0]        sweep_cnt_q, sweep_cnt_d;
  logic [WORD_IDX_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [SET_W-1:0]        fill_set_q, fill_set_d;
  logic [WAY_W-1:0]        fill_way_q, fill_way_d;
  logic                    fill_done_q, fill_done_d;
  logic                    rd_valid_q, rd_valid_d;
  logic [WAY_W-1:0]        rd_way_q, rd_way_d;

  logic                    cpu_wr, cpu_rd, fill_wr;
  logic [SET_W-1:0]        wr_set;
  logic [WORD_IDX_W-1:0]   wr_word;
  logic [BE_W-1:0]         wr_be;
  logic [DATA_W-1:0]       wr_data;
  logic [7:0]              wr_byte;
  logic [DATA_W-1:0]       sel_rdata;
  logic [WORD_WIDTH-1:0]   rd_word_data;
  logic [DATA_W-1:0]       bank_rdata [WAYS];

  assign init_busy  = (state_q == ST_INIT);
  assign req_ready  = (state_q == ST_IDLE) && !fill_start;
  assign fill_ready = (state_q == ST_FILL);

  assign cpu_wr  = req_valid && req_ready && req_we;
  assign cpu_rd  = req_valid && req_ready && !req_we;
  assign fill_wr = fill_valid && fill_ready;

  assign wr_set  = fill_wr ? fill_set_q : req_set;
  assign wr_word = fill_wr ? beat_cnt_q : req_word;
  assign wr_be   = fill_wr ? {BE_W{1'b1}} : req_be;

  // Pack write bytes into storage lanes, adding parity when enabled.
  always_comb begin
    wr_data = '0;
    wr_byte = 8'h00;
    for (int l = 0; l < BE_W; l++) begin
      wr_byte = fill_wr ? fill_data[l*8 +: 8] : req_wdata[l*8 +: 8];
      wr_data[l*LANE_W +: 8] = wr_byte;
`ifdef CACHE_DATA_PARITY_EN
      // A fill always writes clean parity, which clears an injected error.
      wr_data[l*LANE_W + 8] = byte_parity(wr_byte) ^ (perr_inject && !fill_wr && (l == 0));
`endif
    end
  end

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    logic we_w;
    logic re_w;
    assign we_w = (cpu_wr && (req_way == WAY_W'(w))) || (fill_wr && (fill_way_q == WAY_W'(w)));
    assign re_w = cpu_rd && (req_way == WAY_W'(w));

    cache_data_bank #(
      .SETS           (SETS),
      .WORDS_PER_LINE (WORDS_PER_LINE),
      .LANES          (BE_W),
      .LANE_W         (LANE_W)
    ) u_bank (
      .clk     (clk),
      .reset   (reset),
      .clr     (state_q == ST_INIT),
      .clr_set (sweep_cnt_q),
      .we      (we_w),
      .wr_set  (wr_set),
      .wr_word (wr_word),
      .wr_be   (wr_be),
      .wr_data (wr_data),
      .re      (re_w),
      .rd_set  (req_set),
      .rd_word (req_word),
      .rd_data (bank_rdata[w])
    );
  end

  assign sel_rdata = bank_rdata[rd_way_q];

`ifdef CACHE_DATA_PARITY_EN
  logic par_err;

  // Strip parity from the selected way and flag any lane mismatch.
  always_comb begin
    rd_word_data = '0;
    par_err      = 1'b0;
    for (int l = 0; l < BE_W; l++) begin
      rd_word_data[l*8 +: 8] = sel_rdata[l*LANE_W +: 8];
      par_err = par_err | (sel_rdata[l*LANE_W + 8] != byte_parity(sel_rdata[l*LANE_W +: 8]));
    end
  end

  assign rd_perr = rd_valid_q && par_err;
`else
  logic perr_inject_unused;

  // Without parity the stored lanes are the data bytes themselves.
  always_comb begin
    rd_word_data = '0;
    for (int l = 0; l < BE_W; l++) begin
      rd_word_data[l*8 +: 8] = sel_rdata[l*LANE_W +: 8];
    end
  end

  assign perr_inject_unused = perr_inject;
  assign rd_perr            = 1'b0;
`endif

  // Control FSM: clear sweep, idle access, and fill beat sequencing.
  always_comb begin
    state_d     = state_q;
    sweep_cnt_d = sweep_cnt_q;
    beat_cnt_d  = beat_cnt_q;
    fill_set_d  = fill_set_q;
    fill_way_d  = fill_way_q;
    fill_done_d = 1'b0;
    rd_valid_d  = cpu_rd;
    rd_way_d    = cpu_rd ? req_way : rd_way_q;
    case (state_q)
      ST_INIT: begin
        sweep_cnt_d = sweep_cnt_q + SET_W'(1);
        if (sweep_cnt_q == LAST_SET) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_INIT;
        end
      end
      ST_IDLE: begin
        if (fill_start) begin
          fill_set_d = fill_set;
          fill_way_d = fill_way;
          beat_cnt_d = '0;
          state_d    = ST_FILL;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FILL: begin
        if (fill_wr) begin
          beat_cnt_d = beat_cnt_q + WORD_IDX_W'(1);
          if (beat_cnt_q == LAST_WORD) begin
            fill_done_d = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            state_d = ST_FILL;
          end
        end else begin
          state_d = ST_FILL;
        end
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // Control registers; reset abandons any fill and restarts the sweep.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_INIT;
      sweep_cnt_q <= '0;
      beat_cnt_q  <= '0;
      fill_set_q  <= '0;
      fill_way_q  <= '0;
      fill_done_q <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_way_q    <= '0;
    end else begin
      state_q     <= state_d;
      sweep_cnt_q <= sweep_cnt_d;
      beat_cnt_q  <= beat_cnt_d;
      fill_set_q  <= fill_set_d;
      fill_way_q  <= fill_way_d;
      fill_done_q <= fill_done_d;
      rd_valid_q  <= rd_valid_d;
      rd_way_q    <= rd_way_d;
    end
  end

  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_word_data;
  assign fill_done = fill_done_q;

endmodule

// File: tb/tb_cache_data_array.sv
// Scoreboard bench for cache_data_array: a bench-side memory model predicts
// every read, queued at issue and compared when rd_valid arrives.
module tb_cache_data_array;

`ifdef CACHE_DATA_PARITY_EN
  localparam logic PAR_EN = 1'b1;
`else
  localparam logic PAR_EN = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        init_busy;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_set;
  logic [1:0]  req_way;
  logic [1:0]  req_word;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        fill_start;
  logic [2:0]  fill_set;
  logic [1:0]  fill_way;
  logic        fill_valid;
  logic [31:0] fill_data;
  logic        fill_ready;
  logic        fill_done;
  logic        rd_perr;
  logic        perr_inject;

  typedef struct {
    logic [31:0] data;
    logic        perr;
  } rd_exp_t;

  rd_exp_t     sb_q[$];
  logic [31:0] mdl     [4][8][4];
  logic        mdl_bad [4][8][4];
  int          n_vec;
  int          n_err;

  cache_data_array u_dut (
    .clk         (clk),
    .reset       (reset),
    .init_busy   (init_busy),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_set     (req_set),
    .req_way     (req_way),
    .req_word    (req_word),
    .req_be      (req_be),
    .req_wdata   (req_wdata),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .fill_start  (fill_start),
    .fill_set    (fill_set),
    .fill_way    (fill_way),
    .fill_valid  (fill_valid),
    .fill_data   (fill_data),
    .fill_ready  (fill_ready),
    .fill_done   (fill_done),
    .rd_perr     (rd_perr),
    .perr_inject (perr_inject)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic mdl_clear();
    for (int w = 0; w < 4; w++)
      for (int s = 0; s < 8; s++)
        for (int d = 0; d < 4; d++) begin
          mdl[w][s][d]     = 32'h0;
          mdl_bad[w][s][d] = 1'b0;
        end
  endtask

  // One clock; afterwards the read port is checked against the scoreboard.
  task automatic step(input logic exp_rd);
    rd_exp_t e;
    @(posedge clk);
    #1;
    check("rd_valid", rd_valid, exp_rd);
    if (rd_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("sb_size", sb_q.size(), 1);
      end else begin
        e = sb_q.pop_front();
        check("rd_data", rd_data, e.data);
        check("rd_perr", rd_perr, e.perr);
      end
    end else begin
      check("rd_perr_idle", rd_perr, 1'b0);
    end
  endtask

  task automatic cpu_write(input logic [2:0] s, input logic [1:0] w, input logic [1:0] d,
                           input logic [31:0] data, input logic [3:0] be, input logic inj);
    req_valid = 1'b1; req_we = 1'b1; req_set = s; req_way = w; req_word = d;
    req_be = be; req_wdata = data; perr_inject = inj;
    #1;
    check("wr_ready", req_ready, 1'b1);
    step(1'b0);
    for (int b = 0; b < 4; b++)
      if (be[b]) mdl[w][s][d][b*8 +: 8] = data[b*8 +: 8];
    if (be[0]) mdl_bad[w][s][d] = inj;
    req_valid = 1'b0; req_we = 1'b0; perr_inject = 1'b0;
  endtask

  task automatic cpu_read(input logic [2:0] s, input logic [1:0] w, input logic [1:0] d);
    rd_exp_t e;
    req_valid = 1'b1; req_we = 1'b0; req_set = s; req_way = w; req_word = d;
    #1;
    check("rd_ready", req_ready, 1'b1);
    e.data = mdl[w][s][d];
    e.perr = PAR_EN & mdl_bad[w][s][d];
    sb_q.push_back(e);
    step(1'b1);
    req_valid = 1'b0;
  endtask

  task automatic fill_begin(input logic [2:0] s, input logic [1:0] w);
    fill_start = 1'b1; fill_set = s; fill_way = w;
    #1;
    check("fs_req_ready", req_ready, 1'b0);
    step(1'b0);
    fill_start = 1'b0;
  endtask

  // Beat i carries base*(i+1); a bubble is inserted before beat gap_at.
  task automatic fill_beats(input logic [2:0] s, input logic [1:0] w, input logic [31:0] base,
                            input int n_beats, input int gap_at);
    for (int i = 0; i < n_beats; i++) begin
      if (i == gap_at) begin
        fill_valid = 1'b0;
        #1;
        check("gap_req_ready", req_ready, 1'b0);
        step(1'b0);
        check("gap_fill_done", fill_done, 1'b0);
      end
      fill_valid = 1'b1;
      fill_data  = base * (i + 1);
      #1;
      check("fill_ready", fill_ready, 1'b1);
      check("fill_req_ready", req_ready, 1'b0);
      step(1'b0);
      mdl[w][s][i]     = fill_data;
      mdl_bad[w][s][i] = 1'b0;
      check("fill_done", fill_done, (i == 3));
    end
    fill_valid = 1'b0;
  endtask

  task automatic wait_init(input string tag);
    int cyc;
    cyc = 0;
    while (init_busy === 1'b1 && cyc < 64) begin
      step(1'b0);
      cyc++;
    end
    check(tag, cyc, 8);
  endtask

  initial begin
    rd_exp_t e;
    n_vec = 0; n_err = 0;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_set = 3'd0; req_way = 2'd0;
    req_word = 2'd0; req_be = 4'h0; req_wdata = 32'h0; fill_start = 1'b0; fill_set = 3'd0;
    fill_way = 2'd0; fill_valid = 1'b0; fill_data = 32'h0; perr_inject = 1'b0;
    mdl_clear();

    // Reset state
    for (int i = 0; i < 3; i++) step(1'b0);
    check("rst_init_busy", init_busy, 1'b1);
    check("rst_rd_data", rd_data, 32'h0);
    check("rst_fill_done", fill_done, 1'b0);
    check("rst_req_ready", req_ready, 1'b0);
    check("rst_fill_ready", fill_ready, 1'b0);
    reset = 1'b0;
    wait_init("init_cycles");

    // Cleared array reads zero
    cpu_read(3'd5, 2'd2, 2'd3);
    check("clr_read", rd_data, 32'h0);
    step(1'b0);

    // Byte-enable merge, then read-after-write on the following cycle
    cpu_write(3'd1, 2'd0, 2'd2, 32'hAABBCCDD, 4'b1111, 1'b0);
    cpu_write(3'd1, 2'd0, 2'd2, 32'h11223344, 4'b0101, 1'b0);
    cpu_read(3'd1, 2'd0, 2'd2);
    check("be_merge", rd_data, 32'hAA22CC44);
    step(1'b0);
    check("rd_hold", rd_data, 32'hAA22CC44);
    cpu_write(3'd1, 2'd0, 2'd2, 32'hFFFFFFFF, 4'b0000, 1'b0);
    cpu_read(3'd1, 2'd0, 2'd2);
    check("be_zero_noop", rd_data, 32'hAA22CC44);

    // Fill with a bubble before the third beat
    fill_begin(3'd7, 2'd3);
    fill_beats(3'd7, 2'd3, 32'h10, 4, 2);
    step(1'b0);
    check("fill_done_once", fill_done, 1'b0);
    for (int d = 0; d < 4; d++) cpu_read(3'd7, 2'd3, 2'(d));
    check("fill_word3", rd_data, 32'h40);
    step(1'b0);

    // Collision: fill_start wins, the read waits until the fill completes
    req_valid = 1'b1; req_we = 1'b0; req_set = 3'd7; req_way = 2'd3; req_word = 2'd1;
    fill_start = 1'b1; fill_set = 3'd2; fill_way = 2'd1;
    #1;
    check("coll_req_ready", req_ready, 1'b0);
    step(1'b0);
    fill_start = 1'b0;
    check("coll_in_fill", fill_ready, 1'b1);
    fill_beats(3'd2, 2'd1, 32'h55, 4, -1);
    #1;
    check("coll_late_ready", req_ready, 1'b1);
    e.data = mdl[3][7][1];
    e.perr = 1'b0;
    sb_q.push_back(e);
    step(1'b1);
    req_valid = 1'b0;
    check("coll_data", rd_data, 32'h20);
    cpu_read(3'd2, 2'd1, 2'd3);
    step(1'b0);

    // Reset mid-fill: no fill_done, sweep reruns, line reads back zero
    fill_begin(3'd4, 2'd1);
    fill_beats(3'd4, 2'd1, 32'h77, 2, -1);
    reset = 1'b1;
    step(1'b0);
    check("mid_rst_done", fill_done, 1'b0);
    step(1'b0);
    reset = 1'b0;
    mdl_clear();
    check("mid_rst_rd_data", rd_data, 32'h0);
    wait_init("reinit_cycles");
    check("mid_rst_no_done", fill_done, 1'b0);
    cpu_read(3'd4, 2'd1, 2'd0);
    cpu_read(3'd4, 2'd1, 2'd1);
    cpu_read(3'd7, 2'd3, 2'd2);
    check("reinit_clear", rd_data, 32'h0);
    step(1'b0);

    // Parity injection, then a refill clears it
    cpu_write(3'd3, 2'd2, 2'd1, 32'h5A5A0F0F, 4'b1111, 1'b1);
    cpu_read(3'd3, 2'd2, 2'd1);
    check("perr_inject", rd_perr, PAR_EN);
    cpu_read(3'd3, 2'd2, 2'd0);
    fill_begin(3'd3, 2'd2);
    fill_beats(3'd3, 2'd2, 32'h3, 4, -1);
    step(1'b0);
    cpu_read(3'd3, 2'd2, 2'd1);
    check("perr_refill", rd_perr, 1'b0);
    step(1'b0);

    check("sb_drain", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
